// File: rtl/cnn_img_pkg.sv
// Shared image geometry for the frame packer, top_cnn and their benches.
package cnn_img_pkg;

  localparam int IMG_W      = 12;
  localparam int IMG_H      = 12;
  localparam int PIX_W      = 8;
  localparam int NPIX       = IMG_W * IMG_H;
  localparam int FRAME_BITS = NPIX * PIX_W;
  localparam int IDX_W      = $clog2(NPIX);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef logic [IDX_W-1:0]      pix_idx_t;
  typedef logic [PIX_W-1:0]      pix_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  // LSB position of pixel k inside a flat frame; pixel 0 (top-left) sits in the MSBs.
  function automatic logic [BIT_W-1:0] pix_lsb(input int k);
    return BIT_W'(FRAME_BITS - (k + 1) * PIX_W);
  endfunction

endpackage

// File: rtl/img_frame_buf.sv
// One frame of pixel storage: byte-wide indexed write, synchronous clear, flat read.
module img_frame_buf
  import cnn_img_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  input  logic     we,
  input  pix_idx_t idx,
  input  pix_t     wdata,
  output frame_t   img
);

  // Store one pixel per write; clear has priority so a reset always leaves an all-zero frame.
  always_ff @(posedge clk) begin
    // NOTE: this storage is reset on purpose -- out_img must read as zero after reset, not X.
    if (clr) begin
      img <= '0;
    end else if (we) begin
      img[pix_lsb(int'(idx)) +: PIX_W] <= wdata;
    end
  end

endmodule

// File: rtl/img_frame_packer.sv
// Raster pixel stream to flat-frame packer with a ping-pong pair of frame buffers.
module img_frame_packer
  import cnn_img_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  pix_t        in_pix,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output frame_t      out_img,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_sel;
  logic       rd_sel;
  pix_idx_t   pix_cnt;
  pix_idx_t   pix_cnt_nxt;
  pix_idx_t   wr_idx;
  logic       accept;
  logic       resync;
  logic       complete;
  logic       handoff;
  frame_t     img [2];

  // Handshakes look only at registered state, so in_ready never depends on in_valid.
  assign in_ready  = !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign out_img   = img[rd_sel];
  assign handoff   = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  // A start-of-frame in mid-frame restarts the frame with this pixel as index 0.
  assign resync   = accept && in_sof && (pix_cnt != '0);
  assign wr_idx   = resync ? '0 : pix_cnt;
  assign complete = accept && (wr_idx == pix_idx_t'(NPIX - 1));

  // Next full flags and pixel counter; completion and handoff always target different buffers.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    full_nxt    = full;
    pix_cnt_nxt = pix_cnt;
    if (handoff) begin
      full_nxt[rd_sel] = 1'b0;
    end
    if (complete) begin
      full_nxt[wr_sel] = 1'b1;
      pix_cnt_nxt      = '0;
    end else if (accept) begin
      pix_cnt_nxt = wr_idx + pix_idx_t'(1);
    end
  end

  // Control state: flags, selectors, counters and the discard pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      pix_cnt   <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      full      <= full_nxt;
      pix_cnt   <= pix_cnt_nxt;
      frame_err <= resync;
      if (complete) begin
        wr_sel <= !wr_sel;
      end
      if (handoff) begin
        rd_sel    <= !rd_sel;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_buf
    img_frame_buf u_buf (
      .clk   (clk),
      .clr   (rst),
      .we    (accept && (wr_sel == 1'(g))),
      .idx   (wr_idx),
      .wdata (in_pix),
      .img   (img[g])
    );
  end

endmodule

// File: tb/tb_img_frame_packer.sv
// Scoreboard bench for img_frame_packer: the stimulus side models frames as pixel lists,
// the monitor compares every presented frame and the handshake/status outputs each cycle.
module tb_img_frame_packer;
  import cnn_img_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  pix_t        in_pix = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready;
  frame_t      out_img;
  logic        frame_err;
  logic [15:0] frame_cnt;

  logic man_ready = 1'b0;
  logic rand_ready = 1'b0;
  logic rnd_bit = 1'b0;
  assign out_ready = rand_ready ? rnd_bit : man_ready;

  always #5 clk = ~clk;

  img_frame_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_img   (out_img),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_img(input string name, input frame_t act, input frame_t exp);
    bit found = 0;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < NPIX; k++) begin
        if (!found && act[pix_lsb(k) +: PIX_W] !== exp[pix_lsb(k) +: PIX_W]) begin
          found = 1;
          $display("FAIL %s: pixel %0d got %0h expected %0h at %0t", name, k,
                   act[pix_lsb(k) +: PIX_W], exp[pix_lsb(k) +: PIX_W], $time);
        end
      end
      if (!found) $display("FAIL %s: frame differs (unknown bits) at %0t", name, $time);
    end
  endtask

  // Reference model: frames are lists of accepted pixels; a full list becomes an expected frame.
  frame_t      exp_q[$];
  pix_t        cur[$];
  logic [15:0] handed = '0;
  logic        err_exp = 1'b0;
  logic        acc_s = 1'b0;
  logic        sof_s = 1'b0;
  logic        rst_s = 1'b1;
  pix_t        pix_s = '0;

  // Snapshot what the DUT sees at the coming edge.
  initial forever begin
    @(negedge clk);
    acc_s = in_valid && in_ready;
    sof_s = in_sof;
    pix_s = in_pix;
    rst_s = rst;
  end

  // Apply the coming edge to the model.
  initial forever begin
    frame_t f;
    @(posedge clk);
    if (rst_s) begin
      exp_q.delete();
      cur.delete();
      err_exp = 1'b0;
    end else begin
      err_exp = acc_s && sof_s && (cur.size() != 0);
      if (acc_s) begin
        if (err_exp) cur.delete();
        cur.push_back(pix_s);
        if (cur.size() == NPIX) begin
          f = '0;
          for (int k = 0; k < NPIX; k++) f[pix_lsb(k) +: PIX_W] = cur[k];
          exp_q.push_back(f);
          cur.delete();
        end
      end
    end
  end

  // Monitor: compares outputs each cycle and retires a frame on every handoff.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      handed = '0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("frame_err", 32'(frame_err), 32'(err_exp));
      check("frame_cnt", 32'(frame_cnt), 32'(handed));
      if (out_valid && exp_q.size() != 0) check_img("out_img", out_img, exp_q[0]);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        handed = handed + 16'd1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel and hold it until accepted.
  task automatic send(input pix_t p, input logic sof);
    int  guard = 0;
    bit  done  = 0;
    in_valid = 1'b1;
    in_pix   = p;
    in_sof   = sof;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      if (!done) begin
        stalls++;
        guard++;
        if (guard > 3000) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: pixel never accepted at %0t", $time);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // ramp=1 sends pixel value k at index k, otherwise random values.
  task automatic send_frame(input bit ramp, input bit use_sof);
    for (int k = 0; k < NPIX; k++) begin
      send(ramp ? pix_t'(k) : pix_t'($urandom), use_sof && (k == 0));
    end
  endtask

  task automatic single_frame_case();
    man_ready = 1'b0;
    send_frame(1, 1);
    check("sf_out_valid", 32'(out_valid), 32'd1);
    check("sf_top_byte", 32'(out_img[FRAME_BITS-1 -: PIX_W]), 32'h00);
    check("sf_low_byte", 32'(out_img[PIX_W-1:0]), 32'h8F);
    check("sf_frame_cnt", 32'(frame_cnt), 32'd0);
    man_ready = 1'b1;
    idle(1);
    man_ready = 1'b0;
    check("sf_cnt_after", 32'(frame_cnt), 32'd1);
    check("sf_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_img("rst_out_img", out_img, '0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Single frame, then handoff
    single_frame_case();

    // Backpressure: two frames fill both buffers, the third stalls until one handoff
    send_frame(0, 1);
    send_frame(0, 1);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    fork
      send_frame(0, 1);
      begin
        idle(5);
        man_ready = 1'b1;
        idle(1);
        man_ready = 1'b0;
      end
    join
    check("bp_frame_cnt", 32'(frame_cnt), 32'd2);
    check("bp_in_ready_again", 32'(in_ready), 32'd0);

    // Full rate: 10 frames back-to-back by count alone
    man_ready = 1'b1;
    idle(3);
    check("fr_drain_cnt", 32'(frame_cnt), 32'd4);
    stalls = 0;
    for (int f = 0; f < 10; f++) send_frame(0, 0);
    idle(2);
    check("fr_no_stalls", 32'(stalls), 32'd0);
    check("fr_frame_cnt", 32'(frame_cnt), 32'd14);

    // Resync: sof at pixel 50 discards the partial frame
    for (int k = 0; k < 50; k++) send(pix_t'($urandom), k == 0);
    send(8'hA5, 1'b1);
    check("rs_frame_err", 32'(frame_err), 32'd1);
    for (int k = 1; k < NPIX; k++) send(pix_t'($urandom), 1'b0);
    idle(2);
    check("rs_frame_cnt", 32'(frame_cnt), 32'd15);

    // Reset with one frame pending and 70 pixels in flight
    man_ready = 1'b0;
    send_frame(0, 1);
    for (int k = 0; k < 70; k++) send(pix_t'($urandom), k == 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mr_frame_err", 32'(frame_err), 32'd0);
    single_frame_case();

    // Random valid/ready with occasional mid-frame resyncs
    rand_ready = 1'b1;
    for (int f = 0; f < 120; f++) begin
      for (int k = 0; k < NPIX; k++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        send(pix_t'($urandom), (k == 0) || ($urandom_range(0, 299) == 0));
      end
    end
    rand_ready = 1'b0;
    man_ready  = 1'b1;
    idle(10);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
